// File: rtl/adder_pipelined_segmented.sv
// adder_pipelined_segmented
// WIDTH-bit adder/subtractor split into NUM_SEGS segments of SEG_W bits. Each stage adds one
// segment and passes its carry to the next stage. Upper operand segments are skewed through
// the stage registers and finished lower partial sums are deskewed, so one beat leaves as a
// whole after NUM_SEGS cycles. A single advance enable stalls all stages together.
// Optional feature: define ADDER_SAT_EN to replace the sum by signed saturation on overflow.
module adder_pipelined_segmented #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned SEG_W    = 16,
   parameter int unsigned NUM_SEGS = WIDTH / SEG_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   // One pipeline slot. Operand fields hold the full beat; each stage only reads its own
   // segment, so the bits below that segment are dead and trimmed in synthesis.
   typedef struct packed {
      logic             valid;
      logic             ovf;    // only produced by the last stage
      logic             carry;  // carry out of the most recently added segment
      logic [WIDTH-1:0] a;      // operand A
      logic [WIDTH-1:0] b;      // conditioned operand B' (inverted for subtract)
      logic [WIDTH-1:0] s;      // partial sum of the segments added so far
   } stage_t;

   stage_t stage_in [NUM_SEGS];
   stage_t stage_d  [NUM_SEGS];
   stage_t stage_q  [NUM_SEGS];
   logic   adv;

   // A full output slot that nobody takes blocks the whole pipe; otherwise everything moves.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   // Stage inputs: stage 0 takes the ports, stage k takes the register of stage k-1.
   // Each stage then adds its segment and forwards everything else.
   always_comb begin
      stage_t         cur;
      logic [SEG_W:0] seg;
      cur = '0;
      seg = '0;

      stage_in[0].valid = in_valid;
      stage_in[0].ovf   = 1'b0;
      stage_in[0].carry = sub | ci;          // subtract is A + ~B + 1, ci ignored
      stage_in[0].a     = a;
      stage_in[0].b     = sub ? ~b : b;
      stage_in[0].s     = '0;
      for (int unsigned k = 1; k < NUM_SEGS; k++) begin
         stage_in[k] = stage_q[k-1];
      end

      for (int unsigned k = 0; k < NUM_SEGS; k++) begin
         cur = stage_in[k];
         seg = {1'b0, cur.a[k*SEG_W +: SEG_W]} + {1'b0, cur.b[k*SEG_W +: SEG_W]}
               + {{SEG_W{1'b0}}, cur.carry};
         stage_d[k]                     = cur;
         stage_d[k].s[k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
         stage_d[k].carry               = seg[SEG_W];
         if (k == NUM_SEGS - 1) begin
            // Carry into the MSB recovered from the MSB full adder: cin = s ^ a ^ b.
            stage_d[k].ovf = seg[SEG_W-1] ^ cur.a[WIDTH-1] ^ cur.b[WIDTH-1] ^ seg[SEG_W];
`ifdef ADDER_SAT_EN
            // Overflow only happens when A and B' share a sign, so A's sign gives direction.
            if (stage_d[k].ovf) begin
               stage_d[k].s = cur.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
         end
      end
   end

   // Pipeline registers: synchronous reset flushes every in-flight beat, adv moves all stages.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned k = 0; k < NUM_SEGS; k++) begin
            stage_q[k] <= '0;
         end
      end else if (adv) begin
         for (int unsigned k = 0; k < NUM_SEGS; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   assign out_valid = stage_q[NUM_SEGS-1].valid;
   assign sum       = stage_q[NUM_SEGS-1].s;
   assign co        = stage_q[NUM_SEGS-1].carry;
   assign ovf       = stage_q[NUM_SEGS-1].ovf;

endmodule

// File: tb/tb_adder_pipelined_segmented.sv
// Bench for adder_pipelined_segmented: directed carry/borrow/overflow cases, a randomized
// stream with stalls and bubbles against a signed-arithmetic reference model, reset with
// beats in flight, and two small configurations (24/8 and 8/8).
module tb_adder_pipelined_segmented;

   localparam int unsigned W  = 64;
   localparam int unsigned NS = 4;

`ifdef ADDER_SAT_EN
   localparam logic [63:0] POS_OVF_SUM = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] NEG_OVF_SUM = 64'h8000_0000_0000_0000;
   localparam logic [7:0]  SMALL8_SUM  = 8'h7F;
`else
   localparam logic [63:0] POS_OVF_SUM = 64'h8000_0000_0000_0000;
   localparam logic [63:0] NEG_OVF_SUM = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [7:0]  SMALL8_SUM  = 8'h80;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
   logic [W-1:0]  a, b, sum;

   logic          in_valid24, in_ready24, ci24, sub24, out_valid24, out_ready24, co24, ovf24;
   logic [23:0]   a24, b24, sum24;
   logic          in_valid8, in_ready8, ci8, sub8, out_valid8, out_ready8, co8, ovf8;
   logic [7:0]    a8, b8, sum8;

   int            n_total = 0;
   int            n_bad   = 0;

   always #5 clk = ~clk;

   adder_pipelined_segmented #(.WIDTH(64), .SEG_W(16)) dut (
      .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .co(co), .ovf(ovf)
   );

   adder_pipelined_segmented #(.WIDTH(24), .SEG_W(8)) dut24 (
      .CLK(clk), .RST(rst), .in_valid(in_valid24), .in_ready(in_ready24), .a(a24), .b(b24),
      .ci(ci24), .sub(sub24), .out_valid(out_valid24), .out_ready(out_ready24), .sum(sum24),
      .co(co24), .ovf(ovf24)
   );

   adder_pipelined_segmented #(.WIDTH(8), .SEG_W(8)) dut8 (
      .CLK(clk), .RST(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
      .ci(ci8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
      .co(co8), .ovf(ovf8)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: exact signed/unsigned arithmetic, then reduce. Returns {ovf, co, sum}.
   function automatic logic [65:0] ref_model(input logic [63:0] x, input logic [63:0] y,
                                             input logic c, input logic s);
      logic signed [65:0] exact;
      logic        [65:0] uns;
      logic        [63:0] r;
      logic               o, cout;
      if (s) begin
         exact = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
         cout  = (x >= y);                     // no borrow
      end else begin
         exact = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, c});
         uns   = {2'b00, x} + {2'b00, y} + {65'd0, c};
         cout  = uns[64];
      end
      o = exact[64] ^ exact[63];               // result outside the 64-bit signed range
      r = exact[63:0];
`ifdef ADDER_SAT_EN
      if (o) r = exact[65] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
      return {o, cout, r};
   endfunction

   task automatic new_beat();
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
         0: ;
         1: begin a[63:8] = {1'b0, {55{1'b1}}}; b = 64'($urandom_range(0, 511)); end
         2: begin a[63:8] = {1'b1, 55'd0};      b = 64'($urandom_range(0, 511)); end
         default: a = ~64'($urandom_range(0, 3));
      endcase
      ci  = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
   endtask

   task automatic directed(input string tag, input logic [63:0] xa, input logic [63:0] xb,
                           input logic xci, input logic xsub, input logic [63:0] esum,
                           input logic eco, input logic eovf);
      int lat;
      a = xa; b = xb; ci = xci; sub = xsub; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val({tag, ".lat"}, 64'(lat), 64'(NS));
      check_val({tag, ".sum"}, sum, esum);
      check_val({tag, ".co"}, 64'(co), 64'(eco));
      check_val({tag, ".ovf"}, 64'(ovf), 64'(eovf));
      @(posedge clk); #1;
      check_val({tag, ".drain"}, 64'(out_valid), 64'd0);
   endtask

   task automatic stream();
      logic [65:0] q[$];
      logic [65:0] e;
      logic [63:0] held_sum;
      logic        held_co, held_ovf, stall_prev, acc;
      int          acc_n, cyc;
      acc_n = 0; cyc = 0; stall_prev = 1'b0;
      held_sum = '0; held_co = 1'b0; held_ovf = 1'b0;
      new_beat();
      in_valid = 1'b1;
      while ((acc_n < 100 || q.size() > 0) && cyc < 2000) begin
         out_ready = !(cyc inside {[40:42]}) && !(cyc > 60 && $urandom_range(0, 4) == 0);
         @(negedge clk);
         if (stall_prev) begin
            check_val("stream.hold_sum", sum, held_sum);
            check_val("stream.hold_flags", 64'({co, ovf}), 64'({held_co, held_ovf}));
         end
         stall_prev = out_valid && !out_ready;
         if (stall_prev) begin
            check_val("stream.in_ready_stall", 64'(in_ready), 64'd0);
            held_sum = sum; held_co = co; held_ovf = ovf;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check_val("stream.extra_beat", 64'(out_valid), 64'd0);
            end else begin
               e = q.pop_front();
               check_val("stream.sum", sum, e[63:0]);
               check_val("stream.co", 64'(co), 64'(e[64]));
               check_val("stream.ovf", 64'(ovf), 64'(e[65]));
            end
         end
         acc = in_valid && in_ready;
         if (acc) begin
            q.push_back(ref_model(a, b, ci, sub));
            acc_n++;
         end
         @(posedge clk); #1;
         if (acc_n >= 100) begin
            in_valid = 1'b0;
         end else if (acc || !in_valid) begin
            new_beat();
            in_valid = (cyc < 60) || ($urandom_range(0, 7) != 0);
         end
         cyc++;
      end
      check_val("stream.accepted", 64'(acc_n), 64'd100);
      check_val("stream.leftover", 64'(q.size()), 64'd0);
      out_ready = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic stale;
      int   lat24, lat8;
      logic [23:0] s24;
      logic [7:0]  s8;
      logic        c24, o24, c8, o8;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
      in_valid24 = 1'b0; a24 = '0; b24 = '0; ci24 = 1'b0; sub24 = 1'b0; out_ready24 = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset.out_valid", 64'(out_valid), 64'd0);
      check_val("reset.sum", sum, 64'd0);
      check_val("reset.flags", 64'({co, ovf}), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_val("reset.in_ready", 64'(in_ready), 64'd1);

      directed("carry_chain", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h0000_0001_0000_0000, 1'b0, 1'b0);
      directed("all_ones_ci", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
      directed("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      directed("sub_ci_ignored", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      directed("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, POS_OVF_SUM, 1'b0, 1'b1);
      directed("neg_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, NEG_OVF_SUM, 1'b1, 1'b1);

      stream();

      // Three beats in flight, then a one-cycle reset.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         new_beat();
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_val("midrst.out_valid", 64'(out_valid), 64'd0);
      check_val("midrst.sum", sum, 64'd0);
      check_val("midrst.flags", 64'({co, ovf}), 64'd0);
      stale = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         stale = stale | out_valid;
      end
      check_val("midrst.stale", 64'(stale), 64'd0);
      directed("post_rst", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0,
               64'h1234_5678_9ABC_DF01, 1'b0, 1'b0);

      // Small configurations: 3-stage 24-bit and single-stage 8-bit.
      a24 = 24'hFFFFFF; b24 = 24'd1; in_valid24 = 1'b1;
      a8 = 8'h7F; b8 = 8'h01; in_valid8 = 1'b1;
      lat24 = 0; lat8 = 0; s24 = '0; s8 = '0; c24 = 1'b0; o24 = 1'b0; c8 = 1'b0; o8 = 1'b0;
      @(posedge clk); #1;
      in_valid24 = 1'b0; in_valid8 = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         if (out_valid24 && lat24 == 0) begin
            lat24 = i; s24 = sum24; c24 = co24; o24 = ovf24;
         end
         if (out_valid8 && lat8 == 0) begin
            lat8 = i; s8 = sum8; c8 = co8; o8 = ovf8;
         end
         @(posedge clk); #1;
      end
      check_val("w24.lat", 64'(lat24), 64'd3);
      check_val("w24.sum", 64'(s24), 64'd0);
      check_val("w24.flags", 64'({c24, o24}), 64'b10);
      check_val("w8.lat", 64'(lat8), 64'd1);
      check_val("w8.sum", 64'(s8), 64'(SMALL8_SUM));
      check_val("w8.flags", 64'({c8, o8}), 64'b01);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
